// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 memory/IO controller.
package slc3_mem_pkg;

  localparam int unsigned WAIT_STATES_DEF = 2;
  localparam logic [15:0] MMIO_ADDR_DEF   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  // True when an address targets the memory-mapped I/O location instead of SRAM.
  function automatic logic is_mmio(input logic [15:0] addr, input logic [15:0] mmio_addr);
    return (addr == mmio_addr);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous multi-bit inputs (bits are independent).
module sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two register stages so a metastable first flop settles before use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: sequences SRAM accesses with a fixed wait-state count
// and services one memory-mapped address (switches in, hex display out).
module mem_io_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic [15:0] MDR_In,
  output logic        MEM_RDY,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [9:0]  SW,
  output logic [15:0] HEX_DATA
);

  // Counter reload value: ACCESS runs while counting down to zero inclusive.
  localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_STATES - 1);

  mem_state_e  r_state;
  logic [3:0]  r_wait;
  logic        r_rdy;
  logic [15:0] r_mdr_in;
  logic [15:0] r_hex;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic [9:0]  w_sw_sync;

  sync2 #(
    .W (10)
  ) u_sw_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_d     (SW),
    .o_q     (w_sw_sync)
  );

  // Access sequencer: state, wait counter, latched request, strobes and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_rdy    <= 1'b0;
      r_mdr_in <= '0;
      r_hex    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
    end else begin
      // Completion strobe trails the DONE state by one edge.
      r_rdy <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (MEM_REQ) begin
            r_addr  <= MAR;
            r_wdata <= MDR;
            r_we    <= MEM_WE;
            if (is_mmio(MAR, MMIO_ADDR)) begin
              // MMIO completes on the accept edge; SRAM strobes stay idle.
              r_state <= ST_DONE;
              if (MEM_WE) begin
                r_hex <= MDR;
              end else begin
                r_mdr_in <= {6'b0, w_sw_sync};
              end
            end else begin
              r_state <= ST_SETUP;
              r_ce_n  <= 1'b0;
              r_oe_n  <= MEM_WE;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= LP_WAIT_LOAD;
          // Write enable only opens once address and data have had a setup cycle.
          r_we_n  <= ~r_we;
        end
        ST_ACCESS: begin
          if (r_wait == 4'd0) begin
            r_state <= ST_DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (!r_we) begin
              r_mdr_in <= SRAM_DQ_IN;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MDR_In      = r_mdr_in;
  assign MEM_RDY     = r_rdy;
  assign SRAM_ADDR   = r_addr;
  assign SRAM_DQ_OUT = r_wdata;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_WE_N   = r_we_n;
  assign HEX_DATA    = r_hex;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: stimulus pushes expected completions,
// a monitor pops and compares whenever MEM_RDY is seen.
module tb_mem_io_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [15:0] mar   = 16'h0;
  logic [15:0] mdr   = 16'h0;
  logic [9:0]  sw    = 10'h0;

  logic [15:0] mdr_in, sram_addr, dq_out, dq_in, hex;
  logic        rdy, ce_n, oe_n, we_n;

  // Separate request inputs for the WAIT_STATES=1 / 15 instances.
  logic        req_w = 1'b0;
  logic [15:0] mar_w = 16'h0;
  logic [15:0] mdr_in1, addr1, dqo1, dqi1, hex1;
  logic        rdy1, ce1, oe1, we1;
  logic [15:0] mdr_in15, addr15, dqo15, dqi15, hex15;
  logic        rdy15, ce15, oe15, we15;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] rdata;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sbq[$];

  // Strobe observation totals (only written by the observer process).
  int          oe_tot = 0;
  int          ce_tot = 0;
  int          we_tot = 0;
  logic [15:0] we_addr = 16'h0;
  logic [15:0] we_data = 16'h0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-only SRAM contents used by the bench.
  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    case (a)
      16'h0030: return 16'hBEEF;
      16'h0032: return 16'h5A5A;
      default:  return 16'h0000;
    endcase
  endfunction

  assign dq_in = sram_rd(sram_addr);
  assign dqi1  = sram_rd(addr1);
  assign dqi15 = sram_rd(addr15);

  mem_io_ctrl #(.WAIT_STATES(2), .MMIO_ADDR(16'hFFFF)) u_dut (
    .Clk(clk), .Reset_n(rst_n), .MEM_REQ(req), .MEM_WE(we), .MAR(mar), .MDR(mdr),
    .MDR_In(mdr_in), .MEM_RDY(rdy), .SRAM_ADDR(sram_addr), .SRAM_DQ_OUT(dq_out),
    .SRAM_DQ_IN(dq_in), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SW(sw), .HEX_DATA(hex)
  );

  mem_io_ctrl #(.WAIT_STATES(1)) u_ws1 (
    .Clk(clk), .Reset_n(rst_n), .MEM_REQ(req_w), .MEM_WE(1'b0), .MAR(mar_w), .MDR(16'h0),
    .MDR_In(mdr_in1), .MEM_RDY(rdy1), .SRAM_ADDR(addr1), .SRAM_DQ_OUT(dqo1),
    .SRAM_DQ_IN(dqi1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
    .SW(10'h0), .HEX_DATA(hex1)
  );

  mem_io_ctrl #(.WAIT_STATES(15)) u_ws15 (
    .Clk(clk), .Reset_n(rst_n), .MEM_REQ(req_w), .MEM_WE(1'b0), .MAR(mar_w), .MDR(16'h0),
    .MDR_In(mdr_in15), .MEM_RDY(rdy15), .SRAM_ADDR(addr15), .SRAM_DQ_OUT(dqo15),
    .SRAM_DQ_IN(dqi15), .SRAM_CE_N(ce15), .SRAM_OE_N(oe15), .SRAM_WE_N(we15),
    .SW(10'h0), .HEX_DATA(hex15)
  );

  // Count low strobe cycles and capture the bus while write enable is low.
  always @(negedge clk) begin
    if (!oe_n) oe_tot = oe_tot + 1;
    if (!ce_n) ce_tot = ce_tot + 1;
    if (!we_n) begin
      we_tot  = we_tot + 1;
      we_addr = sram_addr;
      we_data = dq_out;
    end
  end

  // Monitor: every MEM_RDY must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rdy) begin
      checks = checks + 1;
      if (sbq.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_rdy: MEM_RDY=1 at cycle %0d with nothing expected", cyc);
      end else begin
        e = sbq.pop_front();
        if (mdr_in !== e.rdata || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL %s: got MDR_In=%h at cycle %0d, expected %h at cycle %0d",
                   e.name, mdr_in, cyc, e.rdata, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input int lat, input string nm);
    int acc;
    @(negedge clk);
    req = 1'b1; we = w; mar = a; mdr = d;
    @(posedge clk); #1;
    acc = cyc;
    sbq.push_back('{exp_rd, acc + lat, nm});
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(posedge clk);
    chk({"drain_", nm}, sbq.size(), 0);
    sbq.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_oe, b_ce, b_we, a, lat1, lat15;
    logic [15:0] r1, r15;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mdr_in", mdr_in, 16'h0);
    chk("rst_hex", hex, 16'h0);
    chk("rst_sram_addr", sram_addr, 16'h0);
    chk("rst_rdy", rdy, 0);
    chk("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // SRAM read
    b_oe = oe_tot; b_ce = ce_tot; b_we = we_tot;
    issue(1'b0, 16'h0030, 16'h0, 16'hBEEF, 4, "rd30");
    drain("rd30");
    chk("rd30_oe_cycles", oe_tot - b_oe, 3);
    chk("rd30_ce_cycles", ce_tot - b_ce, 3);
    chk("rd30_we_cycles", we_tot - b_we, 0);

    // SRAM write leaves MDR_In unchanged
    b_oe = oe_tot; b_ce = ce_tot; b_we = we_tot;
    issue(1'b1, 16'h0031, 16'h1234, 16'hBEEF, 4, "wr31");
    drain("wr31");
    chk("wr31_we_cycles", we_tot - b_we, 2);
    chk("wr31_addr", we_addr, 16'h0031);
    chk("wr31_data", we_data, 16'h1234);
    chk("wr31_oe_cycles", oe_tot - b_oe, 0);

    // MMIO read of synchronized switches, then MMIO write to the hex register
    @(negedge clk);
    sw = 10'h2A5;
    repeat (2) @(posedge clk);
    b_ce = ce_tot;
    issue(1'b0, 16'hFFFF, 16'h0, 16'h02A5, 1, "mmio_rd");
    drain("mmio_rd");
    issue(1'b1, 16'hFFFF, 16'hC0DE, 16'h02A5, 1, "mmio_wr");
    drain("mmio_wr");
    chk("mmio_hex", hex, 16'hC0DE);
    chk("mmio_ce_cycles", ce_tot - b_ce, 0);

    // Held request with MAR changing mid-access
    @(negedge clk);
    req = 1'b1; we = 1'b0; mar = 16'h0030;
    @(posedge clk); #1;
    a = cyc;
    sbq.push_back('{16'hBEEF, a + 4, "stab_first"});
    sbq.push_back('{16'h5A5A, a + 9, "stab_second"});
    @(negedge clk);
    @(negedge clk);
    mar = 16'h0032;
    #1;
    chk("stab_addr_held", sram_addr, 16'h0030);
    for (int i = 0; i < 20 && cyc < a + 5; i++) begin
      @(posedge clk); #1;
    end
    req = 1'b0;
    drain("stab");

    // Reset during the ACCESS phase of a write
    @(negedge clk);
    req = 1'b1; we = 1'b1; mar = 16'h0040; mdr = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rstmid_we_low", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rstmid_mdr_in", mdr_in, 16'h0);
    chk("rstmid_hex", hex, 16'h0);
    chk("rstmid_addr", sram_addr, 16'h0);
    chk("rstmid_dq_out", dq_out, 16'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_no_rdy", rdy, 0);
    issue(1'b0, 16'h0030, 16'h0, 16'hBEEF, 4, "rd_after_rst");
    drain("rd_after_rst");

    // Latency at the wait-state extremes
    lat1 = -1; lat15 = -1; r1 = 16'h0; r15 = 16'h0;
    @(negedge clk);
    req_w = 1'b1; mar_w = 16'h0030;
    @(posedge clk); #1;
    a = cyc;
    @(negedge clk);
    req_w = 1'b0;
    if (rdy1 && lat1 < 0) begin lat1 = cyc - a; r1 = mdr_in1; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rdy1 && lat1 < 0) begin lat1 = cyc - a; r1 = mdr_in1; end
      if (rdy15 && lat15 < 0) begin lat15 = cyc - a; r15 = mdr_in15; end
    end
    chk("ws1_latency", lat1, 3);
    chk("ws1_data", r1, 16'hBEEF);
    chk("ws15_latency", lat15, 17);
    chk("ws15_data", r15, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
